uart_rx_engine: RTL

// - Parametrised UART receive engine: synchroniser, oversampled bit timing, runtime frame format, output holding register.
// - Adds majority-vote sampling, false-start rejection, break detection, overrun reporting and a valid/ready output.
// - Sits between the UART pin and the RX queue; pops into the queue via data_valid/data_ready.

---
 rtl/uart_rx_engine.sv | 393 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   UART receive engine: rx synchroniser, oversampled bit timing with
//   3-sample majority vote, runtime frame format, false-start rejection,
//   break detection, overrun reporting and a valid/ready holding register.
//
//   Optional feature macro: UART_RX_TIMEOUT_EN
//     defined   -> idle timeout counter drives rx_timeout
//     undefined -> no counter logic, rx_timeout tied low
module uart_rx_engine #(
    parameter int DATA_MAX     = 9,
    parameter int OVERSAMPLE   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_clk_en,
    input  logic                rx,
    input  logic [3:0]          cfg_data_bits,
    input  logic                cfg_parity_en,
    input  logic                cfg_parity_odd,
    input  logic                cfg_double_stop_bit,
    output logic [DATA_MAX-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                parity_error,
    output logic                stop_bit_error,
    output logic                overrun_error,
    output logic                break_detect,
    output logic                rx_timeout,
    output logic                busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    // Sample ticks inside one bit period: M-1, M, M+1 with M = OVERSAMPLE/2.
    // The bit decision is taken on the M+1 tick.
    localparam logic [CNT_W-1:0] TICK_A    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_B    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TICK_C    = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DATA_MAX_4 = 4'(DATA_MAX);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } state_t;

    // Majority of three samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity of a received word; unused MSBs are always 0.
    function automatic logic parity_of(input logic [DATA_MAX-1:0] word);
        parity_of = ^word;
    endfunction

    // Out-of-range data-bit requests fall back to the widest frame.
    function automatic logic [3:0] clamp_bits(input logic [3:0] req);
        if ((req < 4'd5) || (req > DATA_MAX_4)) begin
            clamp_bits = DATA_MAX_4;
        end else begin
            clamp_bits = req;
        end
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                  rx_sync_s;
    logic                  rx_prev_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  samp_a_r;
    logic                  samp_b_r;
    logic [3:0]            bit_cnt_r;
    logic [3:0]            bits_r;
    logic                  par_en_r;
    logic                  par_odd_r;
    logic                  dbl_r;
    logic [DATA_MAX-1:0]   data_r;
    logic                  any_one_r;
    logic                  stop_err_r;
    logic                  par_err_r;

    logic                  start_edge_s;
    logic                  decide_s;
    logic                  maj_s;
    logic                  last_bit_s;
    logic                  frame_end_s;
    logic                  any_one_all_s;
    logic                  stop_bad_all_s;
    logic                  brk_s;
    logic                  serr_s;
    logic                  perr_s;
    logic                  good_s;
    logic                  load_s;
    logic                  ovr_s;

    logic [DATA_MAX-1:0]   data_out_r;
    logic                  data_valid_r;
    logic                  parity_error_r;
    logic                  stop_bit_error_r;
    logic                  overrun_error_r;
    logic                  break_detect_r;
    logic                  busy_r;

    // Shift the raw pin through the synchroniser chain (idle high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_sync_s      = sync_r[SYNC_STAGES-1];
    assign start_edge_s   = rx_clk_en & rx_prev_r & ~rx_sync_s;
    assign decide_s       = rx_clk_en & (cnt_r == TICK_C);
    assign maj_s          = majority3(samp_a_r, samp_b_r, rx_sync_s);
    assign last_bit_s     = (bit_cnt_r == (bits_r - 4'd1));

    // The final stop decision folds in the sample being decided right now.
    assign any_one_all_s  = any_one_r | maj_s;
    assign stop_bad_all_s = stop_err_r | ~maj_s;
    assign brk_s          = frame_end_s & ~any_one_all_s;
    assign serr_s         = frame_end_s & any_one_all_s & stop_bad_all_s;
    assign perr_s         = frame_end_s & any_one_all_s & ~stop_bad_all_s & par_err_r;
    assign good_s         = frame_end_s & any_one_all_s & ~stop_bad_all_s & ~par_err_r;
    assign load_s         = good_s & (~data_valid_r | data_ready);
    assign ovr_s          = good_s & data_valid_r & ~data_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and frame-completion decode; moves only on oversample ticks.
    always_comb begin
        state_nxt_s = state_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s) begin
                    if (maj_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s && last_bit_s) begin
                    if (par_en_r) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_STOP1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (decide_s) begin
                    state_nxt_s = ST_STOP1;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (decide_s) begin
                    if (dbl_r) begin
                        state_nxt_s = ST_STOP2;
                    end else begin
                        frame_end_s = 1'b1;
                        if (any_one_all_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_BREAK_WAIT;
                        end
                    end
                end else begin
                    state_nxt_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (decide_s) begin
                    frame_end_s = 1'b1;
                    if (any_one_all_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BREAK_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_STOP2;
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_clk_en && rx_sync_s && (cnt_r == TICK_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, majority samples, frame config latch and data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev_r  <= 1'b1;
            cnt_r      <= CNT_ZERO;
            samp_a_r   <= 1'b1;
            samp_b_r   <= 1'b1;
            bit_cnt_r  <= 4'd0;
            bits_r     <= DATA_MAX_4;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            dbl_r      <= 1'b0;
            data_r     <= {DATA_MAX{1'b0}};
            any_one_r  <= 1'b0;
            stop_err_r <= 1'b0;
            par_err_r  <= 1'b0;
        end else if (rx_clk_en) begin
            rx_prev_r <= rx_sync_s;

            // In BREAK_WAIT the counter measures a run of high ticks instead.
            if (state_r == ST_IDLE) begin
                cnt_r <= CNT_ZERO;
            end else if (state_r == ST_BREAK_WAIT) begin
                if (!rx_sync_s || (cnt_r == TICK_LAST)) begin
                    cnt_r <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else if ((state_nxt_s == ST_BREAK_WAIT) || (cnt_r == TICK_LAST)) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end

            if (cnt_r == TICK_A) begin
                samp_a_r <= rx_sync_s;
            end
            if (cnt_r == TICK_B) begin
                samp_b_r <= rx_sync_s;
            end

            if ((state_r == ST_IDLE) && start_edge_s) begin
                bits_r     <= clamp_bits(cfg_data_bits);
                par_en_r   <= cfg_parity_en;
                par_odd_r  <= cfg_parity_odd;
                dbl_r      <= cfg_double_stop_bit;
                bit_cnt_r  <= 4'd0;
                data_r     <= {DATA_MAX{1'b0}};
                any_one_r  <= 1'b0;
                stop_err_r <= 1'b0;
                par_err_r  <= 1'b0;
            end else if (decide_s) begin
                case (state_r)
                    ST_DATA: begin
                        for (int i = 0; i < DATA_MAX; i++) begin
                            if (bit_cnt_r == 4'(i)) begin
                                data_r[i] <= maj_s;
                            end
                        end
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        any_one_r <= any_one_r | maj_s;
                    end
                    ST_PARITY: begin
                        par_err_r <= maj_s ^ (parity_of(data_r) ^ par_odd_r);
                        any_one_r <= any_one_r | maj_s;
                    end
                    ST_STOP1: begin
                        stop_err_r <= stop_err_r | ~maj_s;
                        any_one_r  <= any_one_r | maj_s;
                    end
                    default: begin
                        any_one_r <= any_one_r;
                    end
                endcase
            end
        end
    end

    // Holding register, valid/ready handshake, error pulses and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_r       <= {DATA_MAX{1'b0}};
            data_valid_r     <= 1'b0;
            parity_error_r   <= 1'b0;
            stop_bit_error_r <= 1'b0;
            overrun_error_r  <= 1'b0;
            break_detect_r   <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            // A load in the same clk as a pop wins: the new word stays valid.
            if (load_s) begin
                data_out_r   <= data_r;
                data_valid_r <= 1'b1;
            end else if (data_valid_r && data_ready) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
            parity_error_r   <= perr_s;
            stop_bit_error_r <= serr_s;
            overrun_error_r  <= ovr_s;
            break_detect_r   <= brk_s;
            busy_r           <= (state_nxt_s != ST_IDLE);
        end
    end

    assign data_out       = data_out_r;
    assign data_valid     = data_valid_r;
    assign parity_error   = parity_error_r;
    assign stop_bit_error = stop_bit_error_r;
    assign overrun_error  = overrun_error_r;
    assign break_detect   = break_detect_r;
    assign busy           = busy_r;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);

    logic             to_armed_r;
    logic [CNT_W-1:0] to_tick_r;
    logic [TO_W-1:0]  to_bits_r;
    logic             to_pulse_r;

    // Count idle bit periods after a good word; fire once, rearm on the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_armed_r <= 1'b0;
            to_tick_r  <= CNT_ZERO;
            to_bits_r  <= {TO_W{1'b0}};
            to_pulse_r <= 1'b0;
        end else begin
            to_pulse_r <= 1'b0;
            if (good_s) begin
                to_armed_r <= 1'b1;
                to_tick_r  <= CNT_ZERO;
                to_bits_r  <= {TO_W{1'b0}};
            end else if ((state_r == ST_IDLE) && start_edge_s) begin
                to_tick_r  <= CNT_ZERO;
                to_bits_r  <= {TO_W{1'b0}};
            end else if (to_armed_r && rx_clk_en && (state_r == ST_IDLE)) begin
                if (to_tick_r == TICK_LAST) begin
                    to_tick_r <= CNT_ZERO;
                    if (to_bits_r == TO_W'(TIMEOUT_BITS - 1)) begin
                        to_pulse_r <= 1'b1;
                        to_armed_r <= 1'b0;
                        to_bits_r  <= {TO_W{1'b0}};
                    end else begin
                        to_bits_r <= to_bits_r + TO_W'(1);
                    end
                end else begin
                    to_tick_r <= to_tick_r + CNT_ONE;
                end
            end
        end
    end

    assign rx_timeout = to_pulse_r;
`else
    localparam int unused_timeout_bits = TIMEOUT_BITS;

    assign rx_timeout = 1'b0;
`endif

endmodule
